// File: rtl/load_ext_pipe.sv
// load_ext_pipe: MEM->WB load-data extender with a 2-entry skid buffer.
// Picks the byte/half/word/dword lane, extends it, and flags misaligned or illegal loads.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (ready while fewer than 2 entries)
//   in_data             raw aligned DM read word
//   in_addr             byte address low bits (bit 2 only used at DATA_W=64)
//   in_lop              0 W, 1 B, 2 BU, 3 H, 4 HU, 5 WU, 6 D, 7 reserved
//   in_tag              pass-through tag (e.g. destination register)
//   out_valid/out_ready downstream handshake on the head entry
//   out_data            extended result (0 when out_err)
//   out_err             misaligned or illegal mode for the head entry
//   out_tag             tag of the head entry
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_addr,
  input  logic [2:0]        in_lop,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int L = (DATA_W == 64) ? 3 : 2;

  logic [L-1:0]      k;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;
  logic              err;

  assign k  = in_addr[L-1:0];
  // Aligned accesses put the lane at bit 0 after this shift;
  // misaligned ones are zeroed below, so one shifter serves all modes.
  assign sh = in_data >> {k, 3'b000};

  always_comb begin
    ext = '0;
    err = 1'b0;
    unique case (1'b1)
      (in_lop == 3'd0): begin
        err = (k[1:0] != 2'b00);
        ext = DATA_W'($signed(sh[31:0]));
      end
      (in_lop == 3'd1): ext = DATA_W'($signed(sh[7:0]));
      (in_lop == 3'd2): ext = DATA_W'(sh[7:0]);
      (in_lop == 3'd3): begin
        err = k[0];
        ext = DATA_W'($signed(sh[15:0]));
      end
      (in_lop == 3'd4): begin
        err = k[0];
        ext = DATA_W'(sh[15:0]);
      end
      (in_lop == 3'd5): begin
        err = (k[1:0] != 2'b00);
        ext = DATA_W'(sh[31:0]);
      end
      (in_lop == 3'd6): begin
        err = (DATA_W != 64) || (k != '0);
        ext = in_data;
      end
      default: err = 1'b1;
    endcase
    if (err) ext = '0;
  end

  logic [1:0]        count;
  logic [DATA_W-1:0] d1;
  logic              e1;
  logic [TAG_W-1:0]  t1;
  logic              push;
  logic              pop;

  assign in_ready  = ~reset & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry lives directly in the output registers; d1/e1/t1 is the skid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_tag  <= '0;
      d1       <= '0;
      e1       <= 1'b0;
      t1       <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            out_data <= ext;
            out_err  <= err;
            out_tag  <= in_tag;
          end else begin
            d1 <= ext;
            e1 <= err;
            t1 <= in_tag;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_data <= d1;
            out_err  <= e1;
            out_tag  <= t1;
          end
          count <= count - 2'd1;
        end
        // Only reachable at count==1: head is consumed and replaced.
        2'b11: begin
          out_data <= ext;
          out_err  <= err;
          out_tag  <= in_tag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// tb_load_ext_pipe: randomized and directed bench for load_ext_pipe.
// Checks a 32-bit and a 64-bit instance against a queue-based reference.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv, ir, ordy, ov, oe;
  logic [31:0] id, od;
  logic [2:0]  ia, il;
  logic [4:0]  it, ot;

  logic        iv6, ir6, ordy6, ov6, oe6;
  logic [63:0] id6, od6;
  logic [2:0]  ia6, il6;
  logic [4:0]  it6, ot6;

  load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(iv), .in_ready(ir),
    .in_data(id), .in_addr(ia), .in_lop(il), .in_tag(it),
    .out_valid(ov), .out_ready(ordy),
    .out_data(od), .out_err(oe), .out_tag(ot)
  );

  load_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(iv6), .in_ready(ir6),
    .in_data(id6), .in_addr(ia6), .in_lop(il6), .in_tag(it6),
    .out_valid(ov6), .out_ready(ordy6),
    .out_data(od6), .out_err(oe6), .out_tag(ot6)
  );

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [4:0]  t;
  } ent_t;

  ent_t q[$];

  // Reference: lane size and sign from the mode, alignment by modulo,
  // value by shift/mask/sign-fill arithmetic.
  function automatic ent_t ref_ext(logic [63:0] data, logic [2:0] addr,
                                   logic [2:0] lop, logic [4:0] tag, int dw);
    ent_t r;
    int nb, a, sz;
    bit sgn, bad;
    logic [63:0] v, m;
    nb = dw / 8;
    a = int'(addr) % nb;
    sz = 1; sgn = 0; bad = 0;
    case (lop)
      3'd0: begin sz = 4; sgn = 1; end
      3'd1: begin sz = 1; sgn = 1; end
      3'd2: begin sz = 1; sgn = 0; end
      3'd3: begin sz = 2; sgn = 1; end
      3'd4: begin sz = 2; sgn = 0; end
      3'd5: begin sz = 4; sgn = 0; end
      3'd6: begin sz = 8; sgn = 0; bad = (dw != 64); end
      default: bad = 1;
    endcase
    if (!bad && (a % sz) != 0) bad = 1;
    r.t = tag;
    r.e = bad;
    if (bad) r.d = '0;
    else begin
      v = data >> (8 * a);
      m = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
      v = v & m;
      if (sgn && v[8*sz-1]) v = v | ~m;
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      r.d = v;
    end
    return r;
  endfunction

  // Advance one clock on the 32-bit instance and move the model along.
  task automatic step32();
    bit push, pop;
    ent_t e;
    push = iv && !reset && (q.size() < 2);
    pop  = ordy && (q.size() != 0);
    e = ref_ext({32'h0, id}, ia, il, it, 32);
    @(posedge clk);
    #1;
    if (reset) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    iv = 1'b0; ordy = 1'b0; id = '0; ia = '0; il = '0; it = '0;
    iv6 = 1'b0; ordy6 = 1'b1; id6 = '0; ia6 = '0; il6 = '0; it6 = '0;
    step32();
    step32();
    ncmp++;
    if (ov !== 1'b0) begin nbad++; $display("FAIL reset_valid got %b want 0", ov); end
    ncmp++;
    if (od !== 32'h0 || oe !== 1'b0 || ot !== 5'd0) begin
      nbad++; $display("FAIL reset_out got %h/%b/%0d want 0/0/0", od, oe, ot);
    end
    ncmp++;
    if (ir !== 1'b0) begin nbad++; $display("FAIL reset_ready got %b want 0", ir); end
    reset = 1'b0;
    #1;
    ncmp++;
    if (ir !== 1'b1) begin nbad++; $display("FAIL post_reset_ready got %b want 1", ir); end
  endtask

  task automatic test_directed();
    logic [2:0]  lop[8]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd0, 3'd7, 3'd6};
    logic [2:0]  adr[8]  = '{3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    logic [31:0] dat[8]  = '{32'h80FF_0000, 32'h12AB_3456, 32'h8001_0000, 32'h0000_F00D,
                             32'h1234_5678, 32'hCAFE_BABE, 32'h5555_AAAA, 32'hFFFF_FFFF};
    logic [31:0] expd[8] = '{32'hFFFF_FF80, 32'h0000_00AB, 32'hFFFF_8001, 32'h0000_F00D,
                             32'h0, 32'h0, 32'h0, 32'h0};
    logic        expe[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv = 1'b1; il = lop[i]; ia = adr[i]; id = dat[i]; it = 5'(i + 9);
      step32();
      iv = 1'b0;
      ncmp++;
      if (ov !== 1'b1 || od !== expd[i] || oe !== expe[i] || ot !== 5'(i + 9)) begin
        nbad++;
        $display("FAIL directed_%0d got v%b %h e%b t%0d want v1 %h e%b t%0d",
                 i, ov, od, oe, ot, expd[i], expe[i], i + 9);
      end
      step32();
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] got[$];
    int next;
    ordy = 1'b0;
    next = 1;
    iv = 1'b1; il = 3'd2; ia = 3'd0; id = 32'h0000_0011; it = 5'd1;
    for (int c = 0; c < 4; c++) begin
      if (iv && ir) begin
        next++;
        step32();
        if (next <= 3) begin
          it = 5'(next); id = 32'(next * 17);
        end else iv = 1'b0;
      end else step32();
    end
    ncmp++;
    if (ir !== 1'b0 || next !== 3) begin
      nbad++; $display("FAIL bp_full got ready %b accepted %0d want 0 2", ir, next - 1);
    end
    ncmp++;
    if (ov !== 1'b1 || ot !== 5'd1) begin
      nbad++; $display("FAIL bp_hold got v%b t%0d want v1 t1", ov, ot);
    end
    ordy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ov && ordy) got.push_back(ot);
      if (iv && ir) begin
        step32();
        iv = 1'b0;
      end else step32();
    end
    ncmp++;
    if (got.size() != 3) begin
      nbad++; $display("FAIL bp_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ncmp++;
        if (got[i] !== 5'(i + 1)) begin
          nbad++; $display("FAIL bp_order_%0d got %0d want %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int outs;
    ordy = 1'b1;
    iv = 1'b1; il = 3'd1; ia = 3'd0; id = $urandom; it = 5'd20;
    e = ref_ext({32'h0, id}, ia, il, it, 32);
    step32();
    outs = 0;
    for (int c = 0; c < 10; c++) begin
      ncmp++;
      if (ov !== 1'b1 || ir !== 1'b1 || od !== e.d[31:0] || oe !== e.e || ot !== e.t) begin
        nbad++;
        $display("FAIL b2b_%0d got v%b r%b %h e%b t%0d want v1 r1 %h e%b t%0d",
                 c, ov, ir, od, oe, ot, e.d[31:0], e.e, e.t);
      end else outs++;
      il = 3'($urandom_range(0, 7)); ia = 3'($urandom); id = $urandom;
      it = 5'(c);
      e = ref_ext({32'h0, id}, ia, il, it, 32);
      step32();
    end
    iv = 1'b0;
    step32();
    ncmp++;
    if (ov !== 1'b0 || outs != 10) begin
      nbad++; $display("FAIL b2b_drain got v%b outs %0d want v0 10", ov, outs);
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    ordy = 1'b0;
    iv = 1'b1; il = 3'd2; ia = 3'd1; id = 32'h0000_7700; it = 5'd4;
    step32();
    it = 5'd5;
    step32();
    ncmp++;
    if (ir !== 1'b0 || ov !== 1'b1) begin
      nbad++; $display("FAIL rm_full got r%b v%b want r0 v1", ir, ov);
    end
    iv = 1'b0;
    reset = 1'b1;
    step32();
    ncmp++;
    if (ov !== 1'b0 || od !== 32'h0) begin
      nbad++; $display("FAIL rm_clear got v%b %h want v0 0", ov, od);
    end
    reset = 1'b0;
    ordy = 1'b1;
    iv = 1'b1; il = 3'd3; ia = 3'd2; id = 32'hF00F_1234; it = 5'd30;
    e = ref_ext({32'h0, id}, ia, il, it, 32);
    step32();
    iv = 1'b0;
    ncmp++;
    if (ov !== 1'b1 || od !== e.d[31:0] || oe !== e.e || ot !== 5'd30) begin
      nbad++;
      $display("FAIL rm_first got v%b %h e%b t%0d want v1 %h e%b t30",
               ov, od, oe, ot, e.d[31:0], e.e);
    end
    step32();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      iv = 1'($urandom); ordy = ($urandom_range(0, 3) != 0);
      il = 3'($urandom); ia = 3'($urandom); id = $urandom; it = 5'($urandom);
      if (il == 3'd0 || il == 3'd5) ia[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : ia[1:0];
      step32();
      ncmp++;
      if (ov !== (q.size() != 0) || ir !== (q.size() < 2)) begin
        nbad++; errs++;
        if (errs < 10)
          $display("FAIL rand_hs_%0d got v%b r%b want v%b r%b",
                   c, ov, ir, q.size() != 0, q.size() < 2);
      end else if (q.size() != 0) begin
        ncmp++;
        if (od !== q[0].d[31:0] || oe !== q[0].e || ot !== q[0].t) begin
          nbad++; errs++;
          if (errs < 10)
            $display("FAIL rand_data_%0d got %h e%b t%0d want %h e%b t%0d",
                     c, od, oe, ot, q[0].d[31:0], q[0].e, q[0].t);
        end
      end
    end
    iv = 1'b0; ordy = 1'b1;
    for (int c = 0; c < 3; c++) step32();
  endtask

  task automatic test_d64();
    ent_t e;
    logic [2:0]  lop[$];
    logic [2:0]  adr[$];
    logic [63:0] dat[$];
    lop = '{3'd5, 3'd6, 3'd6, 3'd0};
    adr = '{3'd4, 3'd0, 3'd4, 3'd4};
    dat = '{64'h8000_0001_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 64'h8000_0001_DEAD_BEEF};
    for (int i = 0; i < 40; i++) begin
      lop.push_back(3'($urandom)); adr.push_back(3'($urandom));
      dat.push_back({$urandom, $urandom});
    end
    ordy6 = 1'b1;
    for (int i = 0; i < lop.size(); i++) begin
      iv6 = 1'b1; il6 = lop[i]; ia6 = adr[i]; id6 = dat[i]; it6 = 5'(i);
      e = ref_ext(id6, ia6, il6, it6, 64);
      if (i == 0) e.d = 64'h0000_0000_8000_0001;
      if (i == 1) e.d = 64'h0123_4567_89AB_CDEF;
      @(posedge clk);
      #1;
      iv6 = 1'b0;
      ncmp++;
      if (ov6 !== 1'b1 || od6 !== e.d || oe6 !== e.e || ot6 !== e.t) begin
        nbad++;
        $display("FAIL d64_%0d got v%b %h e%b t%0d want v1 %h e%b t%0d",
                 i, ov6, od6, oe6, ot6, e.d, e.e, e.t);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_d64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
